// File: rtl/tile_map_pkg.sv
// Shared constants for the tile map and its pixel-generator consumers.
// The FSM encoding and the RAM write-port bundle are also defined here.
package tile_map_pkg;
    localparam int N_PER_ROW     = 60;
    localparam int N_ROWS        = 34;
    localparam int TILES_PER_REG = 4;
    localparam int SPRITE_W      = 8;
    localparam int WORDS         = N_PER_ROW * N_ROWS / TILES_PER_REG;
    localparam int WORD_W        = TILES_PER_REG * SPRITE_W;
    localparam int RAM_ADDR_W    = 9;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef struct packed {
        logic [TILES_PER_REG-1:0] be;
        logic [RAM_ADDR_W-1:0]    addr;
        logic [WORD_W-1:0]        data;
    } ram_wr_t;

    function automatic logic [TILES_PER_REG-1:0] lane_mask(input logic [1:0] lane);
        return TILES_PER_REG'(1) << lane;
    endfunction
endpackage

// File: rtl/tile_map_ctrl_tile_ram.sv
// 512x32 simple dual-port RAM: byte-enable write port, registered read port.
// Read and write share one clock edge, so a same-address access returns the old word.
module tile_ram
    import tile_map_pkg::*;
(
    input  logic                     clk,
    input  logic [TILES_PER_REG-1:0] wr_be,
    input  logic [RAM_ADDR_W-1:0]    wr_addr,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic [RAM_ADDR_W-1:0]    rd_addr,
    output logic [WORD_W-1:0]        rd_data
);
    localparam int DEPTH = 1 << RAM_ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        for (int b = 0; b < TILES_PER_REG; b++) begin
            if (wr_be[b]) begin
                mem[wr_addr][b*SPRITE_W +: SPRITE_W] <= wr_data[b*SPRITE_W +: SPRITE_W];
            end
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;
endmodule

// File: rtl/tile_map_ctrl.sv
// Tile map controller: per-tile sprite writes, whole-map clear FSM and a
// one-cycle-latency word read port for the pixel generator.
module tile_map_ctrl #(
    parameter int         N_PER_ROW = tile_map_pkg::N_PER_ROW,
    parameter int         N_ROWS    = tile_map_pkg::N_ROWS,
    parameter logic [7:0] FILL_RST  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  current_tile,
    output logic [31:0] sprite_addr,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [5:0]  wr_col,
    input  logic [5:0]  wr_row,
    input  logic [7:0]  wr_sprite,
    input  logic        clr_start,
    input  logic [7:0]  clr_value,
    output logic        busy,
    output logic        clr_done,
    output logic        wr_err
);
    import tile_map_pkg::*;

    localparam int                    N_WORDS    = N_PER_ROW * N_ROWS / TILES_PER_REG;
    localparam logic [9:0]            WORDS_LIM  = 10'(N_WORDS);
    localparam logic [RAM_ADDR_W-1:0] LAST_WORD  = RAM_ADDR_W'(N_WORDS - 1);
    localparam logic [6:0]            COL_LIM    = 7'(N_PER_ROW);
    localparam logic [6:0]            ROW_LIM    = 7'(N_ROWS);
    localparam logic [8:0]            ROW_STRIDE = 9'(N_PER_ROW / TILES_PER_REG);

    logic [0:0]            state_reg;
    logic [RAM_ADDR_W-1:0] clr_cnt_reg;
    logic [SPRITE_W-1:0]   fill_reg;
    logic                  clr_done_reg;
    logic                  wr_err_reg;
    logic                  rd_valid_reg;

    logic                  wr_fire;
    logic                  wr_in_range;
    logic [8:0]            wr_word;
    logic [WORD_W-1:0]     fill_word;
    logic [WORD_W-1:0]     sprite_word;
    logic [WORD_W-1:0]     ram_rd_data;
    ram_wr_t               ram_wr;

    assign wr_ready    = (state_reg == ST_IDLE) && !clr_start;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_col} < COL_LIM) && ({1'b0, wr_row} < ROW_LIM);
    // Only meaningful for in-range coordinates; out-of-range writes never reach the RAM.
    assign wr_word     = 9'(wr_row) * ROW_STRIDE + 9'(wr_col[5:2]);

    generate
        for (genvar gi = 0; gi < TILES_PER_REG; gi++) begin : g_lane
            assign fill_word[gi*SPRITE_W +: SPRITE_W]   = fill_reg;
            assign sprite_word[gi*SPRITE_W +: SPRITE_W] = wr_sprite;
        end
    endgenerate

    always_comb begin
        ram_wr = '0;
        if (state_reg == ST_CLEAR) begin
            ram_wr.be   = '1;
            ram_wr.addr = clr_cnt_reg;
            ram_wr.data = fill_word;
        end else if (wr_fire && wr_in_range) begin
            ram_wr.be   = lane_mask(wr_col[1:0]);
            ram_wr.addr = wr_word;
            ram_wr.data = sprite_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_CLEAR;
            clr_cnt_reg  <= '0;
            fill_reg     <= FILL_RST;
            clr_done_reg <= 1'b0;
            wr_err_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            clr_done_reg <= 1'b0;
            wr_err_reg   <= wr_fire && !wr_in_range;
            rd_valid_reg <= {1'b0, current_tile} < WORDS_LIM;
            if (state_reg == ST_IDLE) begin
                if (clr_start) begin
                    state_reg   <= ST_CLEAR;
                    clr_cnt_reg <= '0;
                    fill_reg    <= clr_value;
                end
            end else begin
                if (clr_cnt_reg == LAST_WORD) begin
                    state_reg    <= ST_IDLE;
                    clr_done_reg <= 1'b1;
                end else begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                end
            end
        end
    end

    tile_ram u_tile_ram (
        .clk     (clk),
        .wr_be   (ram_wr.be),
        .wr_addr (ram_wr.addr),
        .wr_data (ram_wr.data),
        .rd_addr (current_tile),
        .rd_data (ram_rd_data)
    );

    // The RAM read register has no reset; out-of-range and reset reads are forced to zero here.
    assign sprite_addr = rd_valid_reg ? ram_rd_data : '0;
    assign busy        = (state_reg == ST_CLEAR);
    assign clr_done    = clr_done_reg;
    assign wr_err      = wr_err_reg;
endmodule
